// File: rtl/udp_frame_pkg.sv
// Shared constants, header layout and FSM state type for the UDP frame writer.
// Default frame geometry: 1600x900 words, double buffered in DRAM.
package udp_frame_pkg;

  localparam int unsigned OFFSET_END = 1440000;
  localparam logic [31:0] BASE0      = 32'h0000_0000;
  localparam logic [31:0] BASE1      = 32'h0100_0000;
  localparam int unsigned MAX_WORDS  = 64;
  localparam int unsigned CNT_W      = $clog2(MAX_WORDS) + 1;
  localparam logic [15:0] RX_PORT    = 16'h4000;

  localparam int unsigned HDR_DST_IP = 0;
  localparam int unsigned HDR_SRC_IP = 1;
  localparam int unsigned HDR_PORTS  = 2;
  localparam int unsigned HDR_SIZE   = 3;

  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_INFO, S_PAYLOAD, S_DROP, S_KICK, S_DRAIN, S_FLIP
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/udp_frame_writer_if.sv
// Receive-port and DRAM-write-engine signals of the UDP frame writer.
// Rx: a packet is taken only while r_ack=1; r_enable then stays high for every
// word of the packet and its fall ends the packet. Engine: kick is a one-cycle
// start, write_num/write_addr hold until the next kick, buf_re pops buf_dout.
interface udp_frame_writer_if;
  logic        r_req;
  logic        r_ack;
  logic        r_enable;
  logic [31:0] r_data;
  logic        kick;
  logic        busy;
  logic [31:0] write_num;
  logic [31:0] write_addr;
  logic [31:0] buf_dout;
  logic        buf_re;

  modport slave (
    input  r_req, r_enable, r_data, busy, buf_re,
    output r_ack, kick, write_num, write_addr, buf_dout
  );

  modport master (
    output r_req, r_enable, r_data, busy, buf_re,
    input  r_ack, kick, write_num, write_addr, buf_dout
  );
endinterface

// File: rtl/udp_rx_fifo.sv
// 64x32 first-word-fall-through FIFO for one packet's payload.
// When empty, dout keeps showing the last word popped (0 after reset).
module udp_rx_fifo
  import udp_frame_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [31:0]      din,
  input  logic             pop,
  output logic [31:0]      dout,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);
  localparam int unsigned AW = CNT_W - 1;

  logic [31:0]   mem [MAX_WORDS];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   last_q;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(MAX_WORDS));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? last_q : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_q <= mem[rd_ptr];
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end
endmodule

// File: rtl/udp_frame_writer.sv
// Parses UDP frame packets, buffers the payload and hands it to the DRAM
// write engine; flips the frame buffer when the last packet of a frame lands.
module udp_frame_writer
  import udp_frame_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  udp_frame_writer_if.slave  bus,
  output logic               frame_select,
  output logic               frame_done,
  output logic [15:0]        drop_cnt,
  output state_t             dbg_state
);
  state_t           state, state_nx;
  logic [1:0]       hdr_idx;
  logic [15:0]      port_q;
  logic [31:0]      size_q;
  logic [30:0]      offset_q;
  logic [CNT_W-1:0] pay_cnt;
  logic             over_q;
  logic             ignore_q;
  logic [1:0]       hold_q;
  logic             kick_q;
  logic [31:0]      write_num_q;
  logic [31:0]      write_addr_q;
  logic             push, drop_inc, stray, info_bad, frame_end;
  logic             fifo_empty, fifo_full;
  logic [CNT_W-1:0] unused_fifo_count;
  logic             unused_req;

  // r_req is advisory only; r_ack alone gates when a packet may start.
  assign unused_req     = bus.r_req;
  assign dbg_state      = state;
  assign bus.kick       = kick_q;
  assign bus.write_num  = write_num_q;
  assign bus.write_addr = write_addr_q;
  assign bus.r_ack      = (state == S_IDLE) && fifo_empty && !bus.busy && !ignore_q;

  assign info_bad  = bus.r_data[31] || (port_q != RX_PORT) ||
                     (({1'b0, bus.r_data[30:0]} + ((size_q - 32'd4) >> 2)) > 32'(OFFSET_END));
  assign frame_end = (({1'b0, offset_q} + 32'(pay_cnt)) == 32'(OFFSET_END));
  // A word arriving after payload end belongs to a packet nobody acked.
  assign stray     = (state inside {S_KICK, S_DRAIN, S_FLIP}) && bus.r_enable && !ignore_q;

  udp_rx_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (bus.r_data),
    .pop   (bus.buf_re),
    .dout  (bus.buf_dout),
    .count (unused_fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    push     = 1'b0;
    drop_inc = stray;
    case (state)
      S_IDLE:    if (bus.r_enable && !ignore_q) state_nx = S_HEADER;
      S_HEADER: begin
        if (!bus.r_enable)                     state_nx = S_DROP;
        else if (hdr_idx == 2'(HDR_SIZE))      state_nx = S_INFO;
      end
      S_INFO:    state_nx = (!bus.r_enable || info_bad) ? S_DROP : S_PAYLOAD;
      S_PAYLOAD: begin
        if (bus.r_enable) begin
          if (pay_cnt < CNT_W'(MAX_WORDS)) push = !fifo_full;
          else if (!over_q)                drop_inc = 1'b1;
        end else begin
          state_nx = (pay_cnt != '0) ? S_KICK : S_IDLE;
        end
      end
      S_DROP: begin
        if (!bus.r_enable) begin
          drop_inc = 1'b1;
          state_nx = S_IDLE;
        end
      end
      S_KICK:    if (!bus.busy) state_nx = S_DRAIN;
      S_DRAIN: begin
        if (hold_q == 2'd0 && fifo_empty && !bus.busy)
          state_nx = frame_end ? S_FLIP : S_IDLE;
      end
      S_FLIP:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_idx      <= '0;
      port_q       <= '0;
      size_q       <= '0;
      offset_q     <= '0;
      pay_cnt      <= '0;
      over_q       <= 1'b0;
      ignore_q     <= 1'b1;
      hold_q       <= '0;
      kick_q       <= 1'b0;
      write_num_q  <= '0;
      write_addr_q <= '0;
      frame_select <= 1'b0;
      frame_done   <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      kick_q     <= 1'b0;
      frame_done <= 1'b0;
      if (!bus.r_enable) ignore_q <= 1'b0;
      else if (stray)    ignore_q <= 1'b1;
      if (drop_inc) drop_cnt <= sat_inc16(drop_cnt);
      case (state)
        S_IDLE:    if (state_nx == S_HEADER) hdr_idx <= 2'd1;
        S_HEADER: begin
          if (bus.r_enable) begin
            hdr_idx <= hdr_idx + 2'd1;
            if (hdr_idx == 2'(HDR_PORTS)) port_q <= bus.r_data[15:0];
            if (hdr_idx == 2'(HDR_SIZE))  size_q <= bus.r_data;
          end
        end
        S_INFO: begin
          offset_q <= bus.r_data[30:0];
          pay_cnt  <= '0;
          over_q   <= 1'b0;
        end
        S_PAYLOAD: begin
          if (push)              pay_cnt <= pay_cnt + 1'b1;
          else if (bus.r_enable) over_q  <= 1'b1;
        end
        S_KICK: begin
          if (state_nx == S_DRAIN) begin
            kick_q       <= 1'b1;
            write_num_q  <= 32'(pay_cnt);
            write_addr_q <= (frame_select ? BASE1 : BASE0) + ({1'b0, offset_q} << 2);
            hold_q       <= 2'd2;
          end
        end
        S_DRAIN:   if (hold_q != 2'd0) hold_q <= hold_q - 2'd1;
        S_FLIP: begin
          frame_select <= !frame_select;
          frame_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_udp_frame_writer.sv
// Bench for udp_frame_writer: directed and random packets against a
// packet-level reference model plus a DRAM engine emulator that pops the FIFO.
module tb_udp_frame_writer;
  import udp_frame_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_select, frame_done;
  logic [15:0] drop_cnt;
  state_t      dbg_state;
  logic        eng_busy = 1'b0;
  logic        hold_busy = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  bit          m_fsel = 1'b0;
  int          m_drop = 0;
  int          m_kicks = 0;
  int          m_done = 0;
  logic [31:0] exp_num = '0;
  logic [31:0] exp_addr = '0;
  logic [31:0] exp_q[$];

  // observations
  int          kicks = 0;
  int          dones = 0;
  logic [31:0] last_num = '0;
  logic [31:0] last_addr = '0;

  always #5 clk = ~clk;

  udp_frame_writer_if bus();
  assign bus.busy = eng_busy | hold_busy;

  udp_frame_writer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .frame_select (frame_select),
    .frame_done   (frame_done),
    .drop_cnt     (drop_cnt),
    .dbg_state    (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) if (rst_n && frame_done) dones++;

  // DRAM write engine: on kick, verify the request, then pop write_num words.
  initial begin
    bus.buf_re = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.kick) begin
        int n;
        kicks++;
        last_num  = bus.write_num;
        last_addr = bus.write_addr;
        check("write_num", bus.write_num, exp_num);
        check("write_addr", bus.write_addr, exp_addr);
        eng_busy = 1'b1;
        n = (bus.write_num > 32'(MAX_WORDS)) ? MAX_WORDS : int'(bus.write_num);
        for (int i = 0; i < n; i++) begin
          if (exp_q.size() == 0) check("pop_underflow", 32'd1, 32'd0);
          else                   check("buf_dout", bus.buf_dout, exp_q.pop_front());
          bus.buf_re = 1'b1;
          @(negedge clk);
        end
        bus.buf_re = 1'b0;
        eng_busy   = 1'b0;
      end
    end
  end

  task automatic drive_word(input logic [31:0] w);
    bus.r_enable = 1'b1;
    bus.r_data   = w;
    @(negedge clk);
  endtask

  task automatic wait_ack();
    int t = 0;
    while (!bus.r_ack && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!bus.r_ack) check("ack_timeout", 32'd0, 32'd1);
  endtask

  // Model the packet's fate from the acceptance rules, then drive it.
  task automatic send_packet(input logic [15:0] port, input logic [31:0] info,
                             input logic [31:0] size, input int n);
    logic [31:0] data[$];
    bit          accept;
    int          nw;
    longint      span;
    span   = longint'(info[30:0]) + longint'((size - 32'd4) / 4);
    accept = !info[31] && (port == RX_PORT) && (span <= longint'(OFFSET_END));
    nw     = (n > int'(MAX_WORDS)) ? int'(MAX_WORDS) : n;
    for (int i = 0; i < n; i++) data.push_back($urandom);
    if (!accept) m_drop++;
    else begin
      if (n > int'(MAX_WORDS)) m_drop++;
      if (nw > 0) begin
        m_kicks++;
        exp_num  = 32'(nw);
        exp_addr = (m_fsel ? BASE1 : BASE0) + info[30:0] * 4;
        for (int i = 0; i < nw; i++) exp_q.push_back(data[i]);
        if (int'(info[30:0]) + nw == int'(OFFSET_END)) begin
          m_fsel = !m_fsel;
          m_done++;
        end
      end
    end
    bus.r_req = 1'b1;
    wait_ack();
    bus.r_req = 1'b0;
    drive_word($urandom);
    drive_word($urandom);
    drive_word({16'($urandom), port});
    drive_word(size);
    drive_word(info);
    for (int i = 0; i < n; i++) begin
      drive_word(data[i]);
      if (i == 0 && accept) check("fwft_first", bus.buf_dout, data[0]);
    end
    bus.r_enable = 1'b0;
    bus.r_data   = '0;
  endtask

  task automatic settle(input string tag);
    @(negedge clk);
    wait_ack();
    @(negedge clk);
    check({tag, "_kicks"}, kicks, m_kicks);
    check({tag, "_drop_cnt"}, {16'd0, drop_cnt}, m_drop);
    check({tag, "_frame_select"}, {31'd0, frame_select}, {31'd0, m_fsel});
    check({tag, "_frame_done"}, dones, m_done);
    check({tag, "_leftover"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_r_ack"}, {31'd0, bus.r_ack}, 32'd0);
    check({tag, "_kick"}, {31'd0, bus.kick}, 32'd0);
    check({tag, "_write_num"}, bus.write_num, 32'd0);
    check({tag, "_write_addr"}, bus.write_addr, 32'd0);
    check({tag, "_buf_dout"}, bus.buf_dout, 32'd0);
    check({tag, "_frame_select"}, {31'd0, frame_select}, 32'd0);
    check({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
    check({tag, "_drop_cnt"}, {16'd0, drop_cnt}, 32'd0);
    check({tag, "_state"}, {29'd0, dbg_state}, {29'd0, S_IDLE});
  endtask

  initial begin
    int kicks_before;
    bit saw_ack, saw_kick;
    bus.r_req    = 1'b0;
    bus.r_enable = 1'b0;
    bus.r_data   = '0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    send_packet(RX_PORT, 32'h100, 32'd260, 64);
    settle("normal");
    check("normal_num", last_num, 32'd64);
    check("normal_addr", last_addr, 32'h400);

    send_packet(RX_PORT, OFFSET_END - 64, 32'd260, 64);
    settle("frame_end");
    check("frame_end_sel", {31'd0, frame_select}, 32'd1);
    check("frame_end_pulses", dones, 1);

    send_packet(RX_PORT, 32'h0, 32'd260, 16);
    settle("second_frame");
    check("second_frame_addr", last_addr, 32'h0100_0000);

    send_packet(16'h4001, 32'h10, 32'd260, 8);
    settle("bad_port");
    check("bad_port_cnt", {16'd0, drop_cnt}, 32'd1);

    send_packet(RX_PORT, 32'h8000_0010, 32'd260, 8);
    settle("ctrl_pkt");
    check("ctrl_pkt_cnt", {16'd0, drop_cnt}, 32'd2);

    send_packet(RX_PORT, 32'h300, 32'd284, 70);
    settle("oversize");
    check("oversize_num", last_num, 32'd64);

    send_packet(RX_PORT, 32'h400, 32'd260, 10);
    settle("short");
    check("short_num", last_num, 32'd10);

    send_packet(RX_PORT, 32'h500, 32'd260, 32);
    hold_busy    = 1'b1;
    kicks_before = kicks;
    saw_ack      = 1'b0;
    saw_kick     = 1'b0;
    repeat (100) begin
      @(negedge clk);
      saw_ack  |= bus.r_ack;
      saw_kick |= bus.kick;
    end
    check("bp_ack", {31'd0, saw_ack}, 32'd0);
    check("bp_kick", {31'd0, saw_kick}, 32'd0);
    check("bp_kick_count", kicks, kicks_before);
    hold_busy = 1'b0;
    settle("backpressure");

    for (int k = 0; k < 24; k++) begin
      logic [15:0] port;
      logic [31:0] info, size;
      int n, sel;
      sel  = $urandom_range(0, 9);
      n    = $urandom_range(0, 72);
      port = (sel == 0) ? 16'($urandom) : RX_PORT;
      info = $urandom_range(0, OFFSET_END - 80);
      if (sel == 1) info[31] = 1'b1;
      if (sel == 2) begin
        n    = $urandom_range(1, 64);
        info = OFFSET_END - n;
      end
      size = 4 + 4 * n;
      if (sel == 3) size = 4 + 4 * (OFFSET_END - info + 1 + $urandom_range(0, 50));
      if (sel == 4) size = 4 + 4 * (OFFSET_END - info);
      send_packet(port, info, size, n);
      settle("random");
    end

    wait_ack();
    drive_word($urandom);
    drive_word($urandom);
    drive_word({16'h1234, RX_PORT});
    drive_word(32'd260);
    drive_word(32'h200);
    for (int i = 0; i < 20; i++) drive_word($urandom);
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_reset");
    m_fsel = 1'b0;
    m_drop = 0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 44; i++) drive_word($urandom);
    bus.r_enable = 1'b0;
    bus.r_data   = '0;
    settle("post_reset");

    send_packet(RX_PORT, 32'h40, 32'd260, 64);
    settle("after_reset");
    check("after_reset_addr", last_addr, 32'h100);
    check("after_reset_num", last_num, 32'd64);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
